// File: rtl/ram_burst_reader_if.sv
// Output word stream of the burst reader: valid/ready with a last-word marker.
interface ram_burst_reader_if #(
   parameter int DWIDTH = 32
);
   logic [DWIDTH-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ram_burst_reader.sv
// Issues sequential reads to a one-cycle-latency RAM and streams the words
// through a 2-entry buffer with full backpressure.
//
// state  | meaning
// IDLE   | waiting for start; latches base address and length
// RUN    | issuing reads while buffer credit allows
// DRAIN  | all reads issued; waiting for buffer empty and nothing in flight
// FINISH | one-cycle done pulse
module ram_burst_reader #(
   parameter int AWIDTH = 3,
   parameter int DWIDTH = 32,
   parameter int LWIDTH = AWIDTH + 1
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AWIDTH-1:0]    base_addr,
   input  logic [LWIDTH-1:0]    burst_len,
   output logic [AWIDTH-1:0]    ram_addr,
   input  logic [DWIDTH-1:0]    ram_dout,
   ram_burst_reader_if.master   m_if,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] ptr_q, ptr_d;
   logic [LWIDTH-1:0] remaining_q, remaining_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [DWIDTH-1:0] buf_data_q [2];
   logic [DWIDTH-1:0] buf_data_d [2];
   logic [1:0]        buf_last_q, buf_last_d;
   logic              busy_q, busy_d;
   logic              pop;
   logic              issue;

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      remaining_d     = remaining_q;
      count_d         = count_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      buf_data_d      = buf_data_q;
      buf_last_d      = buf_last_q;
      busy_d          = busy_q;
      issue           = 1'b0;
      pop             = (count_q != 2'd0) && m_if.m_ready;

      if (inflight_q) begin
         buf_data_d[wr_ptr_q] = ram_dout;
         buf_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({inflight_q, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d       = base_addr;
               remaining_d = burst_len;
               busy_d      = 1'b1;
               state_d     = (burst_len == '0) ? FINISH : RUN;
            end
         end
         RUN: begin
            // A pop this cycle frees a slot, so a full buffer can still issue.
            if ((remaining_q != '0) &&
                ((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop)) begin
               issue = 1'b1;
            end
            if (issue) begin
               ptr_d       = ptr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
            end
            if (remaining_d == '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((count_d == 2'd0) && !inflight_q) begin
               busy_d  = 1'b0;
               state_d = FINISH;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      inflight_d      = issue;
      inflight_last_d = issue && (remaining_q == {{(LWIDTH-1){1'b0}}, 1'b1});
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         ptr_q           <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         count_q         <= 2'd0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         buf_data_q[0]   <= '0;
         buf_data_q[1]   <= '0;
         buf_last_q      <= 2'b00;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         count_q         <= count_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         buf_data_q      <= buf_data_d;
         buf_last_q      <= buf_last_d;
         busy_q          <= busy_d;
      end
   end

   // Capturing into a full buffer without a pop would lose a word.
   always @(posedge clock) begin
      if (rst_n && inflight_q && !pop) begin
         assert (count_q != 2'd2);
      end
   end

   assign ram_addr     = ptr_q;
   assign m_if.m_valid = (count_q != 2'd0);
   assign m_if.m_data  = buf_data_q[rd_ptr_q];
   assign m_if.m_last  = (count_q != 2'd0) && buf_last_q[rd_ptr_q];
   assign busy         = busy_q;
   assign done         = (state_q == FINISH);

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side controller that sits directly upstream of the synchronous-read data RAM (AWIDTH-bit address, DWIDTH-bit data, one-cycle read latency).
- On a start command it issues a burst of sequential addresses, capturing each returned word into a 2-entry output buffer.
- Words are presented on a valid/ready stream with full backpressure support, one word per cycle sustained.
- The RAM's write enable is tied low by the integrator while this block owns the RAM address port.

Parameters:
- AWIDTH, 3, RAM address width; RAM depth = 2^AWIDTH.
- DWIDTH, 32, RAM and stream data width.
- LWIDTH, AWIDTH+1, burst length field width; allows lengths 0..DEPTH.

Ports:
- clock  in  1  rising-edge clock, shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- base_addr  in  AWIDTH  first RAM address of the burst.
- burst_len  in  LWIDTH  number of words to read.
- ram_addr  out  AWIDTH  address to RAM addr input.
- ram_dout  in  DWIDTH  RAM data output; valid the cycle after ram_addr is latched.
- m_data  out  DWIDTH  stream data (buffer head).
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_last  out  1  qualifies the final word of the burst.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the final word handshake.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. Pointer, issue counter, in-flight flag and buffer count clear to 0.
  - Outputs: ram_addr=0, m_valid=0, m_last=0, busy=0, done=0. m_data is don't-care but driven to 0.
  - Reset mid-burst abandons the burst; buffered words are discarded.
- States:
  - IDLE: start=1 latches base_addr into the pointer and burst_len into the remaining count; busy=1 next cycle.
    - If burst_len=0: go to FINISH. Otherwise go to RUN.
  - RUN: issues reads. When the remaining issue count reaches 0, go to DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight, then goes to FINISH.
  - FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
  - start is ignored in any state other than IDLE.
- Address issue:
  - ram_addr equals the pointer register.
  - A read is issued in a RUN cycle when remaining>0 AND (count+inflight<2 OR a pop occurs this cycle).
  - On issue: the pointer increments modulo 2^AWIDTH (wraps 7->0 at default), remaining decrements, and inflight is set for the next cycle.
- Capture:
  - When inflight=1, ram_dout is written into the buffer at the clock edge ending that cycle.
  - Capture and pop in the same cycle leave count unchanged.
  - The credit rule guarantees the buffer never overflows. An overflow is an assertion failure.
- Stream:
  - m_valid = (count>0).
  - A pop occurs when m_valid and m_ready are both high.
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - m_last=1 only on the word whose index equals burst_len-1.
- Latency:
  - Start accepted at edge E0; first address issued in the cycle after E0.
  - First m_valid is high after E2.
  - With m_ready held at 1, one word per cycle follows.
  - done pulses the cycle after the last handshake.
- burst_len=DEPTH: reads every location exactly once, wrapping from base_addr.

Test Plan:
- RAM preloaded mem[i]=i+100; base=2, len=4, m_ready=1 -> m_data 102,103,104,105 on consecutive cycles; m_last on 105; done one cycle later; busy low after done.
- base=6, len=4 -> addresses 6,7,0,1 issued; data 106,107,100,101.
- base=0, len=4; m_ready low for 5 cycles after first m_valid -> m_valid held, m_data=100 stable, no more than 2 words buffered; after release, all 4 words arrive in order with none lost or duplicated.
- len=0 with start -> no m_valid, busy high for one cycle, done pulse.
- start re-asserted during a burst -> ignored; the burst completes unchanged.
- rst_n low mid-burst after 2 words -> all outputs 0 immediately (asynchronously); a new start with base=3, len=2 yields 103,104 normally.
